picorv32_axi: RTL and testbench
===============================

# picorv32_axi

Memory-bus shell of the PicoRV32 processor. It converts the integer core's native single-outstanding memory port into an AXI4-Lite master with separate read and write channels. It sits between the `picorv32` core, which is a separate block attached to the native side, and the system AXI4-Lite memory/peripheral fabric. It holds no data path beyond handshake bookkeeping; all addresses and data pass straight through.

## Interface
- No parameters.
- clk  in  1  single clock; everything is sampled on the rising edge.
- reset  in  1  synchronous, active-high.
- mem_valid  in  1  core request pending; address, data and strobe are stable until mem_ready.
- mem_instr  in  1  request is an instruction fetch.
- mem_addr  in  32  byte address (word-aligned).
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte enables; 0000 means read, non-zero means write.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid when mem_ready is high on a read.
- mem_axi_awvalid/awready  out/in  1  write-address handshake.
- mem_axi_awaddr  out  32  equals mem_addr.
- mem_axi_awprot  out  3  constant 000.
- mem_axi_wvalid/wready  out/in  1  write-data handshake.
- mem_axi_wdata  out  32  equals mem_wdata.
- mem_axi_wstrb  out  4  equals mem_wstrb.
- mem_axi_bvalid/bready  in/out  1  write response.
- mem_axi_arvalid/arready  out/in  1  read-address handshake.
- mem_axi_araddr  out  32  equals mem_addr.
- mem_axi_arprot  out  3  100 for an instruction fetch, otherwise 000.
- mem_axi_rvalid/rready  in/out  1  read data.
- mem_axi_rdata  in  32  read data.

## Operation
- Classification:
  - is_write = mem_valid & |mem_wstrb.
  - is_read = mem_valid & ~|mem_wstrb.
- State registers, all 0 after reset:
  - ack_aw, ack_w, ack_ar.
  - xfer_done.
- Outputs:
  - awvalid = is_write & ~ack_aw & ~xfer_done.
  - wvalid = is_write & ~ack_w & ~xfer_done.
  - arvalid = is_read & ~ack_ar & ~xfer_done.
  - bready = is_write.
  - rready = is_read.
  - mem_ready = (bvalid & bready) | (rvalid & rready).
  - mem_rdata = mem_axi_rdata, passed through combinationally.
- Flag updates each cycle:
  - If reset or xfer_done, clear all ack flags.
  - Otherwise set ack_aw on awvalid&awready, ack_w on wvalid&wready, and ack_ar on arvalid&arready.
  - Flags never clear on their own.
- xfer_done <= ~reset & mem_valid & mem_ready. It blocks re-issue during the cycle in which the core updates mem_valid or its request after completion.
- AW and W are independent: either may be accepted first, in the same cycle, or many cycles apart. The response is accepted only via bvalid; bvalid arriving before both acks is still taken.
- While reset is high, all AXI valid/ready outputs and mem_ready are forced to 0, regardless of mem_valid.
- Exactly one transaction is outstanding at a time. No bursts, IDs or error responses; bresp/rresp are not ported.

## Timing
- Address channels are combinational from the native request. With an always-ready slave, the address handshake completes in the same cycle mem_valid rises.
- Minimum read latency is 1 cycle: arready in cycle N, rvalid in cycle N+1 gives mem_ready in N+1.
- Write latency runs from the later of the AW/W acceptances to bvalid.
- mem_ready is high for exactly the cycle of the rvalid/bvalid handshake. The next request may be presented in the following cycle but issues no AXI valid until xfer_done has cleared, i.e. 2 cycles after the previous completion.
- A valid, once raised, stays high with a stable payload until its ready. This holds provided the core keeps mem_valid and its payload stable, as the native protocol requires.
- Reset asserted mid-transaction clears all flags in the next cycle. Any late rvalid/bvalid for the aborted transfer is then ignored because rready/bready are 0 while no request is pending.

## Structure
- No shared package types are needed. The arprot encoding (instruction = 3'b100) is a package constant alongside other bus constants.
- The block is flat; no sub-module. The `picorv32` core is instantiated beside this shell, not inside it.
- Estimated size is about 150 lines including the port list.

## Test plan
- Read 0x0000_0100 with mem_instr=1; slave arready after 2 cycles, rdata 0xDEADBEEF 3 cycles later -> arprot=100, araddr=0x100, one mem_ready pulse with mem_rdata=0xDEADBEEF, arvalid dropped after acceptance.
- Write 0x0000_0200, data 0x12345678, wstrb 0011; slave takes W 4 cycles before AW -> wvalid drops first, awvalid stays until accepted, awprot=000, single mem_ready on bvalid.
- AW and W accepted in the same cycle with bvalid the next cycle -> mem_ready in that cycle and no duplicate AW/W issued.
- Back-to-back read then write with the slave always ready -> second transaction's valids rise exactly 2 cycles after the first mem_ready; no re-issue of the read.
- Reset asserted while awvalid is pending, and a later stray bvalid arrives -> all valids 0 during reset, flags cleared, mem_ready stays 0.
- Randomized ready/valid delays (0–31 cycles per channel) over 1000 mixed transactions -> every request completes once, payload matches, no valid deasserts before its ready.

Source files
------------

// File: rtl/picorv32_axi_pkg.sv
// Shared bus constants for the PicoRV32 AXI4-Lite memory shell.
// Contents:
//   AXI_ADDR_W / AXI_DATA_W / AXI_STRB_W : native and AXI bus widths
//   AXI_PROT_DATA  : AxPROT for data accesses (unprivileged, secure, data)
//   AXI_PROT_INSTR : AxPROT for instruction fetches (instruction bit set)
package picorv32_axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;

  localparam logic [2:0] AXI_PROT_DATA  = 3'b000;
  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;

endpackage

// File: rtl/picorv32_axi.sv
// Memory-bus shell that turns the PicoRV32 native single-outstanding memory
// port into an AXI4-Lite master. Addresses and data pass straight through;
// the only state is which address/data handshakes have already completed
// for the current request, plus a one-cycle guard after each completion.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   mem_valid/instr/addr/wdata/wstrb : native request from the core
//   mem_ready, mem_rdata        : native completion pulse and read data
//   mem_axi_aw*, mem_axi_w*, mem_axi_b*   : AXI4-Lite write channels
//   mem_axi_ar*, mem_axi_r*     : AXI4-Lite read channels
module picorv32_axi
  import picorv32_axi_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [AXI_ADDR_W-1:0] mem_addr,
  input  logic [AXI_DATA_W-1:0] mem_wdata,
  input  logic [AXI_STRB_W-1:0] mem_wstrb,
  output logic                  mem_ready,
  output logic [AXI_DATA_W-1:0] mem_rdata,

  output logic                  mem_axi_awvalid,
  input  logic                  mem_axi_awready,
  output logic [AXI_ADDR_W-1:0] mem_axi_awaddr,
  output logic [2:0]            mem_axi_awprot,

  output logic                  mem_axi_wvalid,
  input  logic                  mem_axi_wready,
  output logic [AXI_DATA_W-1:0] mem_axi_wdata,
  output logic [AXI_STRB_W-1:0] mem_axi_wstrb,

  input  logic                  mem_axi_bvalid,
  output logic                  mem_axi_bready,

  output logic                  mem_axi_arvalid,
  input  logic                  mem_axi_arready,
  output logic [AXI_ADDR_W-1:0] mem_axi_araddr,
  output logic [2:0]            mem_axi_arprot,

  input  logic                  mem_axi_rvalid,
  output logic                  mem_axi_rready,
  input  logic [AXI_DATA_W-1:0] mem_axi_rdata
);

  logic isWrite;
  logic isRead;
  logic ackAw_q, ackAw_d;
  logic ackW_q,  ackW_d;
  logic ackAr_q, ackAr_d;
  logic xferDone_q, xferDone_d;

  // Classify the pending request. Folding reset in here forces every AXI
  // valid/ready and mem_ready low while reset is held, even if the core
  // still has a request up.
  always_comb begin
    isWrite = ~reset & mem_valid & (|mem_wstrb);
    isRead  = ~reset & mem_valid & ~(|mem_wstrb);
  end

  // Handshake outputs. A channel stays valid until its own ack flag is set;
  // xferDone_q suppresses re-issue while the core updates its request after
  // a completion.
  always_comb begin
    mem_axi_awvalid = isWrite & ~ackAw_q & ~xferDone_q;
    mem_axi_wvalid  = isWrite & ~ackW_q  & ~xferDone_q;
    mem_axi_arvalid = isRead  & ~ackAr_q & ~xferDone_q;
    mem_axi_bready  = isWrite;
    mem_axi_rready  = isRead;
    mem_ready       = (mem_axi_bvalid & mem_axi_bready) |
                      (mem_axi_rvalid & mem_axi_rready);
  end

  // Payload pass-through; arprot marks instruction fetches.
  always_comb begin
    mem_axi_awaddr = mem_addr;
    mem_axi_awprot = AXI_PROT_DATA;
    mem_axi_wdata  = mem_wdata;
    mem_axi_wstrb  = mem_wstrb;
    mem_axi_araddr = mem_addr;
    mem_axi_arprot = mem_instr ? AXI_PROT_INSTR : AXI_PROT_DATA;
    mem_rdata      = mem_axi_rdata;
  end

  // Next-state for the ack flags: they accumulate handshakes for the current
  // request and are wiped in the cycle after a completion.
  always_comb begin
    ackAw_d    = ackAw_q;
    ackW_d     = ackW_q;
    ackAr_d    = ackAr_q;
    xferDone_d = mem_valid & mem_ready;
    if (xferDone_q) begin
      ackAw_d = 1'b0;
      ackW_d  = 1'b0;
      ackAr_d = 1'b0;
    end else begin
      ackAw_d = ackAw_q | (mem_axi_awvalid & mem_axi_awready);
      ackW_d  = ackW_q  | (mem_axi_wvalid  & mem_axi_wready);
      ackAr_d = ackAr_q | (mem_axi_arvalid & mem_axi_arready);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ackAw_q    <= 1'b0;
      ackW_q     <= 1'b0;
      ackAr_q    <= 1'b0;
      xferDone_q <= 1'b0;
    end else begin
      ackAw_q    <= ackAw_d;
      ackW_q     <= ackW_d;
      ackAr_q    <= ackAr_d;
      xferDone_q <= xferDone_d;
    end
  end

endmodule

// File: tb/tb_picorv32_axi.sv
// Self-checking bench for picorv32_axi: directed scenarios followed by
// randomized transactions against a transaction-level slave/core model.
module tb_picorv32_axi;
  import picorv32_axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;

  always #5 clk = ~clk;

  picorv32_axi dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_instr      (mem_instr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .mem_axi_awvalid(mem_axi_awvalid),
    .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr (mem_axi_awaddr),
    .mem_axi_awprot (mem_axi_awprot),
    .mem_axi_wvalid (mem_axi_wvalid),
    .mem_axi_wready (mem_axi_wready),
    .mem_axi_wdata  (mem_axi_wdata),
    .mem_axi_wstrb  (mem_axi_wstrb),
    .mem_axi_bvalid (mem_axi_bvalid),
    .mem_axi_bready (mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid),
    .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr (mem_axi_araddr),
    .mem_axi_arprot (mem_axi_arprot),
    .mem_axi_rvalid (mem_axi_rvalid),
    .mem_axi_rready (mem_axi_rready),
    .mem_axi_rdata  (mem_axi_rdata)
  );

  int checkCount = 0;
  int failCount  = 0;

  // Staged inputs, copied onto the DUT just after each rising edge.
  logic        rstN, validN, instrN;
  logic [31:0] addrN, wdataN;
  logic [3:0]  strbN;

  // Random-phase model state.
  int          txnDone, txnCycles, idleLeft;
  bit          reqActive, gapCycle, aborted, isW;
  logic [31:0] tAddr, tWdata, tRdata;
  logic [3:0]  tStrb;
  logic        tInstr;
  int          awDelay, wDelay, arDelay, respDelay;
  bit          gotAw, gotW, gotAr, respArmed;
  int          awSeen, wSeen, arSeen;
  bit          awPend, wPend, arPend;
  logic [31:0] pAwaddr, pWdata, pAraddr;
  logic [3:0]  pWstrb;
  logic [2:0]  pArprot;
  logic        awr, wr, arr, bv, rv;
  logic [31:0] rd;
  bit          awHs, wHs, arHs;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic setReq(input logic v, input logic instr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
    validN = v;
    instrN = instr;
    addrN  = addr;
    wdataN = wdata;
    strbN  = strb;
  endtask

  // Drive one cycle: apply staged core request and slave signals after the
  // rising edge, then return at the falling edge for sampling.
  task automatic applyStimulus(input logic awrI, input logic wrI, input logic arrI,
                               input logic bvI, input logic rvI, input logic [31:0] rdI);
    @(posedge clk);
    #1;
    reset           = rstN;
    mem_valid       = validN;
    mem_instr       = instrN;
    mem_addr        = addrN;
    mem_wdata       = wdataN;
    mem_wstrb       = strbN;
    mem_axi_awready = awrI;
    mem_axi_wready  = wrI;
    mem_axi_arready = arrI;
    mem_axi_bvalid  = bvI;
    mem_axi_rvalid  = rvI;
    mem_axi_rdata   = rdI;
    @(negedge clk);
  endtask

  function automatic logic [31:0] valids();
    return 32'({mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid});
  endfunction

  function automatic logic [31:0] allHandshakeOuts();
    return 32'({mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid,
                mem_axi_bready, mem_axi_rready, mem_ready});
  endfunction

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
    mem_wdata = '0; mem_wstrb = '0; mem_axi_awready = 1'b0; mem_axi_wready = 1'b0;
    mem_axi_arready = 1'b0; mem_axi_bvalid = 1'b0; mem_axi_rvalid = 1'b0;
    mem_axi_rdata = '0;

    // Reset with a write pending and slave responses active: all forced low.
    rstN = 1'b1;
    setReq(1'b1, 1'b0, 32'h40, 32'hAAAA_5555, 4'hF);
    applyStimulus(1, 1, 1, 1, 1, 32'h0);
    checkOutput("rstOutputs", allHandshakeOuts(), 32'h0);
    applyStimulus(1, 1, 1, 1, 1, 32'h0);
    checkOutput("rstOutputs2", allHandshakeOuts(), 32'h0);
    rstN = 1'b0;
    setReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("idleAfterRst", allHandshakeOuts(), 32'h0);

    // Instruction fetch: arready after 2 cycles, rdata 3 cycles later.
    setReq(1'b1, 1'b1, 32'h100, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t1Valids", valids(), 32'b001);
    checkOutput("t1Araddr", mem_axi_araddr, 32'h100);
    checkOutput("t1Arprot", 32'(mem_axi_arprot), 32'b100);
    checkOutput("t1Rready", 32'(mem_axi_rready), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t1ArHold", valids(), 32'b001);
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    checkOutput("t1ArHs", valids(), 32'b001);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t1ArDrop", valids(), 32'b000);
    checkOutput("t1NoReady", 32'(mem_ready), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t1NoReady2", 32'(mem_ready), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("t1Ready", 32'(mem_ready), 32'd1);
    checkOutput("t1Rdata", mem_rdata, 32'hDEAD_BEEF);
    setReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t1ReadyPulse", 32'(mem_ready), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);

    // Write where W is accepted four cycles before AW.
    setReq(1'b1, 1'b0, 32'h200, 32'h1234_5678, 4'b0011);
    applyStimulus(0, 1, 0, 0, 0, 32'h0);
    checkOutput("t2Valids", valids(), 32'b110);
    checkOutput("t2Awaddr", mem_axi_awaddr, 32'h200);
    checkOutput("t2Awprot", 32'(mem_axi_awprot), 32'b000);
    checkOutput("t2Wdata", mem_axi_wdata, 32'h1234_5678);
    checkOutput("t2Wstrb", 32'(mem_axi_wstrb), 32'b0011);
    checkOutput("t2Bready", 32'(mem_axi_bready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 32'h0);
      checkOutput("t2AwOnly", valids(), 32'b100);
    end
    applyStimulus(1, 0, 0, 0, 0, 32'h0);
    checkOutput("t2AwHs", valids(), 32'b100);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t2Drained", valids(), 32'b000);
    checkOutput("t2NoReady", 32'(mem_ready), 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 32'h0);
    checkOutput("t2Ready", 32'(mem_ready), 32'd1);
    setReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t2ReadyPulse", 32'(mem_ready), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);

    // AW and W in the same cycle, bvalid the next.
    setReq(1'b1, 1'b0, 32'h300, 32'hCAFE_F00D, 4'hF);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    checkOutput("t3Valids", valids(), 32'b110);
    applyStimulus(1, 1, 0, 1, 0, 32'h0);
    checkOutput("t3NoDup", valids(), 32'b000);
    checkOutput("t3Ready", 32'(mem_ready), 32'd1);
    setReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);

    // Back-to-back read then write with an always-ready slave.
    setReq(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    applyStimulus(1, 1, 1, 0, 0, 32'h0);
    checkOutput("t4ArValid", valids(), 32'b001);
    checkOutput("t4ArprotData", 32'(mem_axi_arprot), 32'b000);
    applyStimulus(1, 1, 1, 0, 1, 32'h5A5A_1234);
    checkOutput("t4ReadReady", 32'(mem_ready), 32'd1);
    checkOutput("t4Rdata", mem_rdata, 32'h5A5A_1234);
    checkOutput("t4NoReissue", valids(), 32'b000);
    setReq(1'b1, 1'b0, 32'h404, 32'h0102_0304, 4'hF);
    applyStimulus(1, 1, 1, 0, 0, 32'h0);
    checkOutput("t4Gap", valids(), 32'b000);
    applyStimulus(1, 1, 1, 0, 0, 32'h0);
    checkOutput("t4WriteIssue", valids(), 32'b110);
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    checkOutput("t4WriteReady", 32'(mem_ready), 32'd1);
    checkOutput("t4WriteNoDup", valids(), 32'b000);
    setReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);

    // Reset while awvalid is pending, then a stray bvalid.
    setReq(1'b1, 1'b0, 32'h500, 32'h11, 4'hF);
    applyStimulus(0, 1, 0, 0, 0, 32'h0);
    checkOutput("t5Valids", valids(), 32'b110);
    rstN = 1'b1;
    applyStimulus(0, 0, 0, 1, 1, 32'h0);
    checkOutput("t5RstOutputs", allHandshakeOuts(), 32'h0);
    rstN = 1'b0;
    setReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 1, 0, 32'h0);
    checkOutput("t5StrayB", 32'({mem_axi_bready, mem_ready}), 32'b00);
    setReq(1'b1, 1'b0, 32'h504, 32'h22, 4'h1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t5FlagsCleared", valids(), 32'b110);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    checkOutput("t5Hs", valids(), 32'b110);
    applyStimulus(0, 0, 0, 1, 0, 32'h0);
    checkOutput("t5Ready", 32'(mem_ready), 32'd1);
    setReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);

    // bvalid before either address/data ack is still taken.
    setReq(1'b1, 1'b0, 32'h600, 32'h33, 4'h8);
    applyStimulus(0, 0, 0, 1, 0, 32'h0);
    checkOutput("t6EarlyB", 32'(mem_ready), 32'd1);
    setReq(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t6Idle", valids(), 32'b000);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);

    // Randomized phase: slave readies appear after 0-31 cycle countdowns,
    // responses follow 0-31 cycles after the last needed acceptance.
    txnDone = 0; idleLeft = 0; reqActive = 0; gapCycle = 0; aborted = 0;
    isW = 0; tAddr = '0; tWdata = '0; tRdata = '0; tStrb = '0; tInstr = 0;
    txnCycles = 0; respDelay = 0; respArmed = 0;
    gotAw = 0; gotW = 0; gotAr = 0; awSeen = 0; wSeen = 0; arSeen = 0;
    awPend = 0; wPend = 0; arPend = 0;
    pAwaddr = '0; pWdata = '0; pAraddr = '0; pWstrb = '0; pArprot = '0;
    awDelay = $urandom_range(0, 31);
    wDelay  = $urandom_range(0, 31);
    arDelay = $urandom_range(0, 31);

    while (txnDone < 1000 && !aborted) begin
      if (!reqActive) begin
        if (idleLeft == 0) begin
          reqActive = 1;
          tAddr     = $urandom() & 32'hFFFF_FFFC;
          tWdata    = $urandom();
          tRdata    = $urandom();
          tStrb     = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          isW       = (tStrb != 4'h0);
          tInstr    = isW ? 1'b0 : 1'($urandom_range(0, 1));
          txnCycles = 0;
        end else begin
          idleLeft--;
        end
      end

      if (reqActive) setReq(1'b1, tInstr, tAddr, tWdata, tStrb);
      else setReq(1'b0, 1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      awr = (awDelay == 0);
      wr  = (wDelay == 0);
      arr = (arDelay == 0);
      bv  = reqActive && isW && respArmed && (respDelay == 0);
      rv  = reqActive && !isW && respArmed && (respDelay == 0);
      rd  = rv ? tRdata : $urandom();
      applyStimulus(awr, wr, arr, bv, rv, rd);

      if (gapCycle) checkOutput("gapNoValid", valids(), 32'b000);
      gapCycle = 0;

      if (awPend) begin
        checkOutput("awHold", 32'(mem_axi_awvalid), 32'd1);
        checkOutput("awAddrHold", mem_axi_awaddr, pAwaddr);
      end
      if (wPend) begin
        checkOutput("wHold", 32'(mem_axi_wvalid), 32'd1);
        checkOutput("wDataHold", mem_axi_wdata, pWdata);
        checkOutput("wStrbHold", 32'(mem_axi_wstrb), 32'(pWstrb));
      end
      if (arPend) begin
        checkOutput("arHold", 32'(mem_axi_arvalid), 32'd1);
        checkOutput("arAddrHold", mem_axi_araddr, pAraddr);
        checkOutput("arProtHold", 32'(mem_axi_arprot), 32'(pArprot));
      end

      awHs = mem_axi_awvalid && awr;
      wHs  = mem_axi_wvalid && wr;
      arHs = mem_axi_arvalid && arr;
      if (awHs) begin
        awSeen++;
        gotAw = 1;
        checkOutput("awAddr", mem_axi_awaddr, tAddr);
        checkOutput("awProt", 32'(mem_axi_awprot), 32'd0);
      end
      if (wHs) begin
        wSeen++;
        gotW = 1;
        checkOutput("wData", mem_axi_wdata, tWdata);
        checkOutput("wStrb", 32'(mem_axi_wstrb), 32'(tStrb));
      end
      if (arHs) begin
        arSeen++;
        gotAr = 1;
        checkOutput("arAddr", mem_axi_araddr, tAddr);
        checkOutput("arProt", 32'(mem_axi_arprot), tInstr ? 32'd4 : 32'd0);
      end

      awPend  = mem_axi_awvalid && !awr;
      wPend   = mem_axi_wvalid && !wr;
      arPend  = mem_axi_arvalid && !arr;
      pAwaddr = mem_axi_awaddr;
      pWdata  = mem_axi_wdata;
      pWstrb  = mem_axi_wstrb;
      pAraddr = mem_axi_araddr;
      pArprot = mem_axi_arprot;

      if (mem_ready) begin
        checkOutput("readyWithReq", 32'(reqActive), 32'd1);
        if (!isW) checkOutput("rdata", mem_rdata, tRdata);
        checkOutput("awCount", 32'(awSeen), isW ? 32'd1 : 32'd0);
        checkOutput("wCount", 32'(wSeen), isW ? 32'd1 : 32'd0);
        checkOutput("arCount", 32'(arSeen), isW ? 32'd0 : 32'd1);
        reqActive = 0;
        txnDone++;
        gapCycle  = 1;
        idleLeft  = $urandom_range(0, 2);
        awSeen = 0; wSeen = 0; arSeen = 0;
        gotAw = 0; gotW = 0; gotAr = 0; respArmed = 0;
        awPend = 0; wPend = 0; arPend = 0;
      end else if (reqActive) begin
        txnCycles++;
        if (txnCycles > 400) begin
          checkOutput("txnTimeout", 32'(txnCycles), 32'd400);
          aborted = 1;
        end
      end

      if (awHs) awDelay = $urandom_range(0, 31);
      else if (awDelay > 0) awDelay--;
      if (wHs) wDelay = $urandom_range(0, 31);
      else if (wDelay > 0) wDelay--;
      if (arHs) arDelay = $urandom_range(0, 31);
      else if (arDelay > 0) arDelay--;

      if (reqActive && !respArmed && ((isW && gotAw && gotW) || (!isW && gotAr))) begin
        respArmed = 1;
        respDelay = $urandom_range(0, 31);
      end else if (respArmed && respDelay > 0) begin
        respDelay--;
      end
    end

    checkOutput("txnCount", 32'(txnDone), 32'd1000);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
